sipo_decoder: RTL

Serial-to-parallel receiver that reassembles words sent LSB-first over a one-bit data line qualified by a data-transmit strobe. It is the far end of the team's parallel-to-serial encoder link and produces WIDTH-bit words for downstream logic. Incomplete frames are flagged, and words completed while the output is still occupied are flagged. Output delivery uses a valid/ready handshake.

---
 rtl/sipo_decoder_if.sv | 24 ++
 rtl/sipo_decoder.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/sipo_decoder_if.sv
// Handshake and serial-link bundle for sipo_decoder.
// The slave modport is the receiver side; the master modport is the link driver and output consumer.
interface sipo_decoder_if #(
    parameter int WIDTH = 32
);
    logic             serial_in;
    logic             dt_in;
    logic             out_ready;
    logic [WIDTH-1:0] parallel_out;
    logic             out_valid;
    logic             busy;
    logic             frame_error;
    logic             overrun;

    modport master (
        output serial_in, dt_in, out_ready,
        input  parallel_out, out_valid, busy, frame_error, overrun
    );

    modport slave (
        input  serial_in, dt_in, out_ready,
        output parallel_out, out_valid, busy, frame_error, overrun
    );
endinterface

// File: rtl/sipo_decoder.sv
// LSB-first serial-to-parallel receiver with a valid/ready output stage.
// It flags frames that are cut short and words that complete while the held word is still pending.
module sipo_decoder #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    sipo_decoder_if.slave bus
);
    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [WIDTH-1:0] shift_r, shift_s;
    logic [WIDTH-1:0] word_s;
    logic [WIDTH-1:0] parallel_r, parallel_s;
    logic             valid_r, valid_s;
    logic             busy_r;
    logic             ferr_r, ferr_s;
    logic             ovr_r, ovr_s;
    logic             complete_s;

    // Frame FSM: next state, bit counter and shift register.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        shift_s    = shift_r;
        ferr_s     = 1'b0;
        complete_s = 1'b0;
        word_s     = shift_r;
        word_s[WIDTH-1] = bus.serial_in;

        case (state_r)
            IDLE: begin
                if (bus.dt_in) begin
                    shift_s    = {WIDTH{1'b0}};
                    shift_s[0] = bus.serial_in;
                    cnt_s      = CW'(1);
                    state_s    = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (bus.dt_in) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (cnt_r == CW'(i)) begin
                            shift_s[i] = bus.serial_in;
                        end else begin
                            shift_s[i] = shift_r[i];
                        end
                    end
                    if (cnt_r == LAST_IDX) begin
                        complete_s = 1'b1;
                        cnt_s      = {CW{1'b0}};
                        state_s    = DRAIN;
                    end else begin
                        cnt_s   = cnt_r + CW'(1);
                        state_s = SHIFT;
                    end
                end else begin
                    // Strobe dropped mid-word: discard the partial word so no stale bits leak into the next frame.
                    ferr_s  = 1'b1;
                    cnt_s   = {CW{1'b0}};
                    shift_s = {WIDTH{1'b0}};
                    state_s = IDLE;
                end
            end
            DRAIN: begin
                // The transmitter keeps its strobe high for trailing cycles; wait for it to fall.
                if (bus.dt_in) begin
                    state_s = DRAIN;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CW{1'b0}};
                shift_s = {WIDTH{1'b0}};
            end
        endcase
    end

    // Output holding register: load on completion, clear on consumption, flag overrun.
    always_comb begin
        parallel_s = parallel_r;
        valid_s    = valid_r;
        ovr_s      = 1'b0;

        if (complete_s) begin
            if (!valid_r || bus.out_ready) begin
                parallel_s = word_s;
                valid_s    = 1'b1;
            end else begin
                ovr_s = 1'b1;
            end
        end else if (valid_r && bus.out_ready) begin
            valid_s = 1'b0;
        end else begin
            valid_s = valid_r;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= {CW{1'b0}};
            shift_r    <= {WIDTH{1'b0}};
            parallel_r <= {WIDTH{1'b0}};
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
            ferr_r     <= 1'b0;
            ovr_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            shift_r    <= shift_s;
            parallel_r <= parallel_s;
            valid_r    <= valid_s;
            busy_r     <= (state_s == SHIFT);
            ferr_r     <= ferr_s;
            ovr_r      <= ovr_s;
        end
    end

    assign bus.parallel_out = parallel_r;
    assign bus.out_valid    = valid_r;
    assign bus.busy         = busy_r;
    assign bus.frame_error  = ferr_r;
    assign bus.overrun      = ovr_r;
endmodule
